// File: rtl/data_bus_unit_if.sv
// Bus bundle between the accumulator controller and its downstream data bus unit,
// including the output FIFO drain and the external input port handshakes.
interface data_bus_unit_if #(
    parameter int DATA_W = 32
);
    logic [7:0]        addr;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] busIn;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output addr, rd, wr, wdata, out_ready, in_data, in_valid,
        input  busIn, out_data, out_valid, in_ready
    );

    modport slave (
        input  addr, rd, wr, wdata, out_ready, in_data, in_valid,
        output busIn, out_data, out_valid, in_ready
    );
endinterface

// File: rtl/data_bus_unit.sv
// Non-stalling bus slave: data RAM, memory-mapped output FIFO, one-entry input
// port and a status/control register, with a registered one-cycle read return.
module data_bus_unit #(
    parameter int DATA_W     = 32,
    parameter int RAM_WORDS  = 240,
    parameter int FIFO_DEPTH = 4
) (
    input logic           CLK,
    input logic           RST,
    data_bus_unit_if.slave bus
);
    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [7:0]       RAM_LIMIT = 8'(RAM_WORDS);
    localparam logic [7:0]       ADDR_FIFO = 8'hF0;
    localparam logic [7:0]       ADDR_IN   = 8'hF1;
    localparam logic [7:0]       ADDR_STAT = 8'hF2;
    localparam logic [PTR_W-1:0] PTR_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        IN_EMPTY = 1'b0,
        IN_FULL  = 1'b1
    } in_state_t;

    function automatic logic [DATA_W-1:0] status_word(
        input logic             ovf,
        input logic             in_full,
        input logic             full,
        input logic [CNT_W-1:0] cnt
    );
        logic [DATA_W-1:0] w;
        w       = '0;
        w[7:0]  = 8'(cnt);
        w[8]    = full;
        w[9]    = in_full;
        w[10]   = ovf;
        return w;
    endfunction

    logic [DATA_W-1:0] ram [RAM_WORDS];
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              overflow;
    logic [DATA_W-1:0] in_reg;
    in_state_t         in_state;
    in_state_t         in_state_nxt;
    logic [DATA_W-1:0] rdata_p1;
    logic [DATA_W-1:0] rd_mux;

    logic is_ram;
    logic push_req;
    logic push;
    logic pop;
    logic ovf_set;
    logic stat_wr;
    logic fifo_full;
    logic in_full;
    logic in_load;
    logic in_pop;

    // Address decode and FIFO handshake qualification
    assign is_ram    = (bus.addr < RAM_LIMIT);
    assign fifo_full = (count == CNT_FULL);
    assign in_full   = (in_state == IN_FULL);
    assign pop       = bus.out_valid && bus.out_ready;
    assign push_req  = bus.wr && (bus.addr == ADDR_FIFO);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push      = push_req && (!fifo_full || pop);
    assign ovf_set   = push_req && fifo_full && !pop;
    assign stat_wr   = bus.wr && (bus.addr == ADDR_STAT);

    assign bus.out_valid = (count != '0);
    assign bus.out_data  = fifo_mem[rd_ptr];
    assign bus.in_ready  = (in_state == IN_EMPTY);
    assign bus.busIn     = rdata_p1;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        in_state_nxt = in_state;
        in_load      = 1'b0;
        in_pop       = 1'b0;
        case (in_state)
            IN_EMPTY: begin
                if (bus.in_valid) begin
                    in_load      = 1'b1;
                    in_state_nxt = IN_FULL;
                end
            end
            IN_FULL: begin
                if (bus.rd && (bus.addr == ADDR_IN)) begin
                    in_pop       = 1'b1;
                    in_state_nxt = IN_EMPTY;
                end
            end
            default: in_state_nxt = IN_EMPTY;
        endcase
    end

    // Read mux sees pre-update state, so status and RAM reads return old values
    always_comb begin
        rd_mux = '0;
        if (is_ram) begin
            rd_mux = ram[bus.addr[RAM_AW-1:0]];
        end else begin
            case (bus.addr)
                ADDR_IN:   rd_mux = in_pop ? in_reg : '0;
                ADDR_STAT: rd_mux = status_word(overflow, in_full, fifo_full, count);
                default:   rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            in_state <= IN_EMPTY;
        end else begin
            in_state <= in_state_nxt;
        end
    end

    // Stage p1: registered read return plus control state
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata_p1 <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            in_reg   <= '0;
        end else begin
            rdata_p1 <= bus.rd ? rd_mux : '0;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_nxt;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (stat_wr) begin
                overflow <= 1'b0;
            end
            if (in_load) begin
                in_reg <= bus.in_data;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (bus.wr && is_ram) begin
            ram[bus.addr[RAM_AW-1:0]] <= bus.wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.wdata;
        end
    end
endmodule

// File: tb/tb_data_bus_unit.sv
// Directed self-checking bench for data_bus_unit: RAM access, FIFO push/drain and
// overflow, input port FSM, status register and mid-operation reset.
module tb_data_bus_unit;
    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    data_bus_unit_if bus ();

    data_bus_unit dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wr    = 1'b1;
        cycle();
        bus.wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a);
        bus.addr = a;
        bus.rd   = 1'b1;
        cycle();
        bus.rd   = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        cycle();
        cycle();
        RST = 1'b0;
        checks++;
        if (bus.busIn !== 32'h0) begin
            errors++;
            $display("FAIL reset_busIn got %h want %h", bus.busIn, 32'h0);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        bus_read(8'hF2);
        checks++;
        if (bus.busIn !== 32'h0) begin
            errors++;
            $display("FAIL reset_status got %h want %h", bus.busIn, 32'h0);
        end
    endtask

    task automatic test_ram();
        bus_write(8'h05, 32'hDEADBEEF);
        bus_read(8'h05);
        checks++;
        if (bus.busIn !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL ram_read got %h want %h", bus.busIn, 32'hDEADBEEF);
        end
        cycle();
        checks++;
        if (bus.busIn !== 32'h0) begin
            errors++;
            $display("FAIL ram_idle got %h want %h", bus.busIn, 32'h0);
        end
        bus_write(8'hEF, 32'hCAFE0123);
        bus_read(8'hEF);
        checks++;
        if (bus.busIn !== 32'hCAFE0123) begin
            errors++;
            $display("FAIL ram_last_word got %h want %h", bus.busIn, 32'hCAFE0123);
        end
        // Same-address read and write: old value returned, new value stored
        bus_write(8'h10, 32'h11111111);
        bus.addr  = 8'h10;
        bus.wdata = 32'h22222222;
        bus.wr    = 1'b1;
        bus.rd    = 1'b1;
        cycle();
        bus.wr    = 1'b0;
        bus.rd    = 1'b0;
        checks++;
        if (bus.busIn !== 32'h11111111) begin
            errors++;
            $display("FAIL rdwr_old got %h want %h", bus.busIn, 32'h11111111);
        end
        bus_read(8'h10);
        checks++;
        if (bus.busIn !== 32'h22222222) begin
            errors++;
            $display("FAIL rdwr_new got %h want %h", bus.busIn, 32'h22222222);
        end
        bus_write(8'hF5, 32'h55555555);
        bus_read(8'hF5);
        checks++;
        if (bus.busIn !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read got %h want %h", bus.busIn, 32'h0);
        end
    endtask

    task automatic test_fifo_overflow();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus_write(8'hF0, 32'(i));
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_out_valid got %b want 1", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 32'd1) begin
            errors++;
            $display("FAIL ovf_head got %h want %h", bus.out_data, 32'd1);
        end
        bus_read(8'hF2);
        // overflow bit10, fifo_full bit8, count 4
        checks++;
        if (bus.busIn !== 32'h0000_0504) begin
            errors++;
            $display("FAIL ovf_status got %h want %h", bus.busIn, 32'h0000_0504);
        end
        bus_read(8'hF0);
        checks++;
        if (bus.busIn !== 32'h0) begin
            errors++;
            $display("FAIL fifo_port_read got %h want %h", bus.busIn, 32'h0);
        end
    endtask

    task automatic test_fifo_drain();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (bus.out_data !== 32'(i) || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL drain_%0d got %h valid %b want %h valid 1", i, bus.out_data, bus.out_valid, 32'(i));
            end
            cycle();
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty got %b want 0", bus.out_valid);
        end
        bus_write(8'hF2, 32'hFFFFFFFF);
        bus_read(8'hF2);
        checks++;
        if (bus.busIn !== 32'h0) begin
            errors++;
            $display("FAIL ovf_clear got %h want %h", bus.busIn, 32'h0);
        end
    endtask

    task automatic test_push_pop_full();
        bus.out_ready = 1'b0;
        for (int i = 5; i <= 8; i++) begin
            bus_write(8'hF0, 32'(i));
        end
        bus.out_ready = 1'b1;
        bus_write(8'hF0, 32'd9);
        bus.out_ready = 1'b0;
        bus_read(8'hF2);
        checks++;
        if (bus.busIn !== 32'h0000_0104) begin
            errors++;
            $display("FAIL pushpop_status got %h want %h", bus.busIn, 32'h0000_0104);
        end
        bus.out_ready = 1'b1;
        for (int i = 6; i <= 9; i++) begin
            checks++;
            if (bus.out_data !== 32'(i) || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL pushpop_drain_%0d got %h valid %b want %h valid 1", i, bus.out_data, bus.out_valid, 32'(i));
            end
            cycle();
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_empty got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_input_port();
        bus_read(8'hF1);
        checks++;
        if (bus.busIn !== 32'h0) begin
            errors++;
            $display("FAIL in_empty_read got %h want %h", bus.busIn, 32'h0);
        end
        bus.in_data  = 32'h1234;
        bus.in_valid = 1'b1;
        cycle();
        bus.in_data  = 32'h5555;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_full got %b want 0", bus.in_ready);
        end
        cycle();
        bus.in_valid = 1'b0;
        bus_read(8'hF2);
        checks++;
        if (bus.busIn !== 32'h0000_0200) begin
            errors++;
            $display("FAIL in_status got %h want %h", bus.busIn, 32'h0000_0200);
        end
        bus_read(8'hF1);
        checks++;
        if (bus.busIn !== 32'h1234) begin
            errors++;
            $display("FAIL in_pop got %h want %h", bus.busIn, 32'h1234);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_after_pop got %b want 1", bus.in_ready);
        end
        bus_read(8'hF1);
        checks++;
        if (bus.busIn !== 32'h0) begin
            errors++;
            $display("FAIL in_second_pop got %h want %h", bus.busIn, 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus_write(8'hF0, 32'(i + 16));
        end
        bus.in_data  = 32'hABCD;
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        // A read issued together with reset must not come back
        bus.addr = 8'h05;
        bus.rd   = 1'b1;
        RST      = 1'b1;
        cycle();
        RST      = 1'b0;
        bus.rd   = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busIn !== 32'h0) begin
            errors++;
            $display("FAIL midreset got valid %b ready %b busIn %h want 0 1 0", bus.out_valid, bus.in_ready, bus.busIn);
        end
        bus_read(8'hF2);
        checks++;
        if (bus.busIn !== 32'h0) begin
            errors++;
            $display("FAIL midreset_status got %h want %h", bus.busIn, 32'h0);
        end
        bus_read(8'h05);
        checks++;
        if (bus.busIn !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL ram_kept got %h want %h", bus.busIn, 32'hDEADBEEF);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        RST           = 1'b1;
        bus.addr      = 8'h00;
        bus.rd        = 1'b0;
        bus.wr        = 1'b0;
        bus.wdata     = 32'h0;
        bus.out_ready = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_valid  = 1'b0;
        #1;
        test_reset();
        test_ram();
        test_fifo_overflow();
        test_fifo_drain();
        test_push_pop_full();
        test_input_port();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
